digit_serial_adder: RTL

Parametrised, multi-cycle two's-complement adder/subtractor for the multiplier datapath. It generalises the single-bit half-add cell to a WIDTH-bit operand pair processed DIGIT bits per clock, with a ripple carry held in a register between digits. Operands enter through a valid/ready handshake, and results are returned with carry-out and signed-overflow flags. It serves as the area-lean final carry-propagate stage after the reduction tree, and as a general accumulator adder.

---
 rtl/digit_serial_adder.sv | 81 ++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle two's-complement add/sub, DIGIT bits per clock with a registered ripple carry.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_params
        $error("digit_serial_adder: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;
    logic             cin_msb;

    assign dsum     = {1'b0, sa[DIGIT-1:0]} + {1'b0, sb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Carry into the digit's top bit recovered from its sum bit and operand bits.
    assign cin_msb  = sa[DIGIT-1] ^ sb[DIGIT-1] ^ dsum[DIGIT-1];
    assign in_ready = !rst && state == IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sa    <= a;
                    sb    <= b ^ {WIDTH{sub}};
                    carry <= sub;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    for (int i = 0; i < N; i++)
                        if (cnt == CW'(i)) sum[i*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
                    carry <= dsum[DIGIT];
                    sa    <= sa >> DIGIT;
                    sb    <= sb >> DIGIT;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        cout      <= dsum[DIGIT];
                        ovf       <= cin_msb ^ dsum[DIGIT];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
